// File: rtl/cache_pkg.sv
// Shared data-cache definitions: line geometry, refill FSM encoding and address field helpers.
// Used by the refill buffer, the word-select mux and the tag RAM wrapper.
package cache_pkg;

    localparam int LINE_BITS  = 512;
    localparam int WORD_BITS  = 32;
    localparam int LINE_WORDS = 16;
    localparam int BEAT_W     = $clog2(LINE_WORDS);

    localparam int OFFSET_LEN = 6;
    localparam int INDEX_LEN  = 6;
    localparam int ADDR_W     = 32;
    localparam int TAG_LEN    = ADDR_W - INDEX_LEN - OFFSET_LEN;

    typedef logic [1:0] refill_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    function automatic logic [BEAT_W-1:0] word_sel(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_LEN-1:2];
    endfunction

    function automatic logic [INDEX_LEN-1:0] line_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_LEN +: INDEX_LEN];
    endfunction

    function automatic logic [TAG_LEN-1:0] line_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_LEN];
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_refill_buffer_if.sv
// Bundle of the refill buffer's requester, burst-read and way-RAM fill signals.
// The refill buffer uses the master view; its environment uses the slave view.
interface dcache_refill_buffer_if
    import cache_pkg::*;
#(
    parameter int Offset_len = 6,
    parameter int Index_len  = 6,
    parameter int Addr_width = 32
);

    localparam int TAG_W = Addr_width - Index_len - Offset_len;

    logic                  miss_req;
    logic [Addr_width-1:0] miss_addr;
    logic                  victim_way;
    logic                  miss_ready;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [Addr_width-1:0] ar_addr;
    logic [7:0]            ar_len;

    logic                  r_valid;
    logic                  r_ready;
    logic [WORD_BITS-1:0]  r_data;
    logic                  r_last;

    logic                  crit_valid;
    logic [WORD_BITS-1:0]  crit_word;

    logic [1:0]            refill_we;
    logic [Index_len-1:0]  refill_index;
    logic [TAG_W-1:0]      refill_tag;
    logic [LINE_BITS-1:0]  refill_line;
    logic                  refill_err;

    modport master (
        input  miss_req, miss_addr, victim_way, ar_ready, r_valid, r_data, r_last,
        output miss_ready, ar_valid, ar_addr, ar_len, r_ready, crit_valid, crit_word,
               refill_we, refill_index, refill_tag, refill_line, refill_err
    );

    modport slave (
        output miss_req, miss_addr, victim_way, ar_ready, r_valid, r_data, r_last,
        input  miss_ready, ar_valid, ar_addr, ar_len, r_ready, crit_valid, crit_word,
               refill_we, refill_index, refill_tag, refill_line, refill_err
    );

endinterface

// File: rtl/dcache_refill_buffer.sv
// Miss refill: one 16-beat burst read assembled into a 512-bit line, written to the victim way
// in a single cycle, with the missed word forwarded as soon as its beat arrives.
module dcache_refill_buffer
    import cache_pkg::*;
#(
    parameter int Offset_len = 6,
    parameter int Index_len  = 6,
    parameter int Addr_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    dcache_refill_buffer_if.master  bus
);

    localparam int TAG_W = Addr_width - Index_len - Offset_len;

    refill_state_t          state;
    logic [Addr_width-1:0]  addr_q;
    logic                   way_q;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [LINE_BITS-1:0]   line_buf;
    logic [LINE_BITS-1:0]   line_q;
    logic [WORD_BITS-1:0]   crit_word_q;
    logic                   crit_valid_q;
    logic                   err_q;

    logic [LINE_BITS-1:0]   line_next;
    logic                   last_beat;
    logic                   crit_beat;
    logic                   beat_acc;

    assign last_beat = (beat_cnt == BEAT_W'(LINE_WORDS - 1));
    assign crit_beat = (beat_cnt == addr_q[Offset_len-1:2]);
    assign beat_acc  = (state == ST_DATA) && bus.r_valid;

    always_comb begin
        line_next = line_buf;
        line_next[beat_cnt*WORD_BITS +: WORD_BITS] = bus.r_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            way_q        <= 1'b0;
            beat_cnt     <= '0;
            line_buf     <= '0;
            line_q       <= '0;
            crit_word_q  <= '0;
            crit_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            crit_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.miss_req) begin
                        addr_q   <= bus.miss_addr;
                        way_q    <= bus.victim_way;
                        err_q    <= 1'b0;
                        beat_cnt <= '0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus.ar_ready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        line_buf <= line_next;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (crit_beat) begin
                            crit_word_q  <= bus.r_data;
                            crit_valid_q <= 1'b1;
                        end
                        // r_last is only advisory: the beat count alone ends the burst
                        if (bus.r_last != last_beat) err_q <= 1'b1;
                        if (last_beat) begin
                            line_q <= line_next;
                            state  <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.miss_ready   = (state == ST_IDLE);
    assign bus.ar_valid     = (state == ST_ADDR);
    assign bus.ar_addr      = {addr_q[Addr_width-1:Offset_len], {Offset_len{1'b0}}};
    assign bus.ar_len       = 8'(LINE_WORDS - 1);
    assign bus.r_ready      = (state == ST_DATA);
    assign bus.crit_valid   = crit_valid_q;
    assign bus.crit_word    = crit_word_q;
    assign bus.refill_we    = (state == ST_WRITE) ? (way_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.refill_index = addr_q[Offset_len +: Index_len];
    assign bus.refill_tag   = addr_q[Addr_width-1 -: TAG_W];
    assign bus.refill_line  = line_q;
    assign bus.refill_err   = err_q;

endmodule

// File: tb/tb_dcache_refill_buffer.sv
// Directed bench for dcache_refill_buffer: a cycle-level expectation model driven from the
// stimulus schedule, checked every cycle, plus hand-computed literal expectations.
module tb_dcache_refill_buffer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_refill_buffer_if bus ();

    dcache_refill_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // expectation model state
    logic         chk_en = 1'b0;
    logic         e_ready, e_arv, e_rr, e_cv, e_err, e_zero;
    logic [1:0]   e_we;
    logic [31:0]  e_arad, e_cw;
    logic [511:0] e_line;
    logic [5:0]   e_idx;
    logic [19:0]  e_tag;
    logic         m_err;

    // snapshots taken by the compare process
    logic [31:0]  cap_arad, cap_cw;
    logic [511:0] cap_line;
    logic [5:0]   cap_idx;
    logic [1:0]   cap_we;
    int           cv_cnt = 0;
    int           we_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("miss_ready", bus.miss_ready, e_ready);
            chk("ar_valid", bus.ar_valid, e_arv);
            chk("r_ready", bus.r_ready, e_rr);
            chk("refill_we", bus.refill_we, e_we);
            chk("crit_valid", bus.crit_valid, e_cv);
            chk("refill_err", bus.refill_err, e_err);
            chk("ar_len", bus.ar_len, 8'd15);
            chk("refill_line", bus.refill_line, e_line);
            if (e_arv) begin
                chk("ar_addr", bus.ar_addr, e_arad);
                cap_arad <= bus.ar_addr;
            end
            if (e_cv) begin
                chk("crit_word", bus.crit_word, e_cw);
                cap_cw <= bus.crit_word;
            end
            if (e_we != 2'b00) begin
                chk("refill_index", bus.refill_index, e_idx);
                chk("refill_tag", bus.refill_tag, e_tag);
                cap_line <= bus.refill_line;
                cap_idx  <= bus.refill_index;
                cap_we   <= bus.refill_we;
            end
            if (e_zero) begin
                chk("rst_crit_word", bus.crit_word, 32'h0);
                chk("rst_ar_addr", bus.ar_addr, 32'h0);
                chk("rst_index", bus.refill_index, 6'h0);
                chk("rst_tag", bus.refill_tag, 20'h0);
            end
            if (bus.crit_valid) cv_cnt <= cv_cnt + 1;
            if (bus.refill_we != 2'b00) we_cnt <= we_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One miss from acceptance to the first IDLE cycle after the write. last_at is the beat
    // carrying r_last (-1: none); rst_after >= 0 asserts reset right after that beat.
    task automatic run_miss(input logic [31:0] addr, input logic way, input int ar_dly,
                            input bit gaps, input int last_at, input int rst_after,
                            input bit hold, input logic [31:0] hold_addr,
                            input logic [31:0] dbase, output int lat);
        logic [31:0]  beat_d [16];
        logic [511:0] line;
        int           t0, beat, crit_i;
        bit           crit_next, tog, v;
        for (int k = 0; k < 16; k++) beat_d[k] = dbase + 32'(k);
        line = '0;
        for (int k = 0; k < 16; k++) line[32*k +: 32] = beat_d[k];
        crit_i = int'(addr[5:2]);

        bus.miss_req = 1'b1; bus.miss_addr = addr; bus.victim_way = way;
        e_ready = 1'b1; e_arv = 1'b0; e_rr = 1'b0; e_we = 2'b00; e_cv = 1'b0;
        e_err = m_err; e_zero = 1'b0;
        t0 = cyc;
        step();

        bus.miss_req = hold;
        if (hold) bus.miss_addr = hold_addr;
        m_err = 1'b0;
        e_ready = 1'b0; e_err = 1'b0; e_arv = 1'b1; e_arad = {addr[31:6], 6'b0};
        for (int k = 0; k <= ar_dly; k++) begin
            bus.ar_ready = (k == ar_dly);
            step();
        end
        bus.ar_ready = 1'b0; e_arv = 1'b0; e_rr = 1'b1;

        beat = 0; tog = 1'b1; crit_next = 1'b0;
        while (beat < 16 && !(rst_after >= 0 && beat > rst_after)) begin
            e_cv = crit_next;
            if (crit_next) e_cw = beat_d[crit_i];
            e_err = m_err;
            crit_next = 1'b0;
            v = gaps ? tog : 1'b1;
            tog = ~tog;
            bus.r_valid = v;
            bus.r_data  = v ? beat_d[beat] : 32'hDEAD_BEEF;
            bus.r_last  = v ? (beat == last_at) : 1'b1;
            if (v) begin
                if (beat == crit_i) crit_next = 1'b1;
                if ((beat == last_at) != (beat == 15)) m_err = 1'b1;
                beat++;
            end
            step();
        end
        bus.r_valid = 1'b0; bus.r_last = 1'b0;

        if (rst_after >= 0) begin
            rst = 1'b1;
            e_cv = crit_next; e_err = m_err;
            step();
            rst = 1'b0;
            m_err = 1'b0;
            e_ready = 1'b1; e_rr = 1'b0; e_cv = 1'b0; e_err = 1'b0; e_zero = 1'b1;
            e_line = '0;
            for (int k = 0; k < 4; k++) begin
                bus.r_valid = k[0];
                step();
            end
            bus.r_valid = 1'b0;
            e_zero = 1'b0;
        end else begin
            e_rr = 1'b0; e_we = way ? 2'b10 : 2'b01;
            e_cv = crit_next;
            if (crit_next) e_cw = beat_d[crit_i];
            e_err = m_err; e_line = line; e_idx = addr[11:6]; e_tag = addr[31:12];
            step();
            e_we = 2'b00; e_cv = 1'b0; e_ready = 1'b1;
        end
        lat = cyc - t0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int           lat, cv0, we0;
        logic [511:0] basic_line;

        rst = 1'b1;
        bus.miss_req = 1'b0; bus.miss_addr = '0; bus.victim_way = 1'b0;
        bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_last = 1'b0;
        e_ready = 1'b1; e_arv = 1'b0; e_rr = 1'b0; e_cv = 1'b0; e_err = 1'b0; e_zero = 1'b1;
        e_we = 2'b00; e_arad = '0; e_cw = '0; e_line = '0; e_idx = '0; e_tag = '0;
        m_err = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        e_zero = 1'b0;

        // basic fill
        cv0 = cv_cnt;
        run_miss(32'h0000_1A48, 1'b1, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'hA0, lat);
        chk("basic_latency", lat, 19);
        chk("basic_ar_addr", cap_arad, 32'h0000_1A40);
        chk("basic_crit_word", cap_cw, 32'hA2);
        chk("basic_crit_pulses", cv_cnt - cv0, 1);
        chk("basic_we", cap_we, 2'b10);
        chk("basic_word2", cap_line[95:64], 32'hA2);
        chk("basic_word15", cap_line[511:480], 32'hAF);
        chk("basic_index", cap_idx, 6'h29);
        basic_line = cap_line;

        // stalled handshakes
        we0 = we_cnt;
        run_miss(32'h0000_1A48, 1'b1, 5, 1'b1, 15, -1, 1'b0, 32'h0, 32'hA0, lat);
        chk("stall_latency", lat, 39);
        chk("stall_line", cap_line, basic_line);
        chk("stall_we_cycles", we_cnt - we0, 1);

        // critical word at the line edges
        run_miss(32'h0000_2000, 1'b0, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'h100, lat);
        chk("edge0_crit_word", cap_cw, 32'h100);
        chk("edge0_we", cap_we, 2'b01);
        run_miss(32'h0000_203C, 1'b0, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'h200, lat);
        chk("edge15_crit_word", cap_cw, 32'h20F);

        // protocol errors
        run_miss(32'h0000_4010, 1'b0, 0, 1'b0, 7, -1, 1'b0, 32'h0, 32'h300, lat);
        chk("early_last_err", bus.refill_err, 1'b1);
        chk("early_last_word15", cap_line[511:480], 32'h30F);
        chk("early_last_latency", lat, 19);
        run_miss(32'h0000_4020, 1'b1, 0, 1'b0, -1, -1, 1'b0, 32'h0, 32'h400, lat);
        chk("missing_last_err", bus.refill_err, 1'b1);
        run_miss(32'h0000_4030, 1'b1, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'h480, lat);
        chk("err_cleared", bus.refill_err, 1'b0);

        // back-pressure on the requester
        run_miss(32'h0000_5000, 1'b0, 0, 1'b0, 15, -1, 1'b1, 32'h0000_6104, 32'h500, lat);
        chk("bp_first_latency", lat, 19);
        run_miss(32'h0000_6104, 1'b1, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'h600, lat);
        chk("bp_second_ar_addr", cap_arad, 32'h0000_6100);
        chk("bp_second_crit", cap_cw, 32'h601);

        // reset in the middle of DATA
        cv0 = cv_cnt;
        we0 = we_cnt;
        run_miss(32'h0000_3030, 1'b0, 0, 1'b0, 15, 8, 1'b0, 32'h0, 32'h700, lat);
        chk("rst_no_crit", cv_cnt - cv0, 0);
        chk("rst_no_write", we_cnt - we0, 0);
        run_miss(32'h0000_7008, 1'b1, 0, 1'b0, 15, -1, 1'b0, 32'h0, 32'h800, lat);
        chk("post_rst_crit", cap_cw, 32'h802);
        chk("post_rst_latency", lat, 19);

        step();
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
